// File: rtl/xvs_pkg.sv
// Shared definitions for the Xillybus read-stream arbiter: header layout,
// FSM state encoding and the round-robin requester search.
package xvs_pkg;

    localparam int MAX_SRC       = 8;
    localparam int ID_W          = 3;
    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_ID_LSB    = 16;
    localparam int HDR_ID_W      = 8;
    localparam int HDR_LEN_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // First set bit of req at or after ptr, wrapping modulo n.
    function automatic logic [ID_W-1:0] rr_first(input logic [MAX_SRC-1:0] req,
                                                 input logic [ID_W-1:0]    ptr,
                                                 input int                 n);
        logic [ID_W-1:0] sel;
        logic            found;
        int              idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_SRC; i++) begin
            idx = (int'(ptr) + i) % n;
            if (!found && (i < n) && req[idx[ID_W-1:0]]) begin
                sel   = idx[ID_W-1:0];
                found = 1'b1;
            end else begin
                sel   = sel;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/xillybus_rd_fifo.sv
// Synchronous FIFO with flush and a registered (non-FWFT) read port.
// A pop frees the slot a same-cycle push needs, so push+pop at full keeps occupancy.
module xillybus_rd_fifo #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_nxt;
    logic          push;
    logic          pop;

    // Push/pop qualification and next occupancy.
    always_comb begin
        pop       = rd_en & ~empty & ~flush;
        push      = wr_en & ~flush & (~full | pop);
        count_nxt = count_r;
        if (flush) begin
            count_nxt = '0;
        end else if (push & ~pop) begin
            count_nxt = count_r + 1'b1;
        end else if (pop & ~push) begin
            count_nxt = count_r - 1'b1;
        end else begin
            count_nxt = count_r;
        end
    end

    // Pointers, flags and the registered read word.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            rd_data <= '0;
        end else begin
            count_r <= count_nxt;
            full    <= (count_nxt == FULL_CNT);
            empty   <= (count_nxt == '0);
            if (flush) begin
                wptr_r <= '0;
                rptr_r <= '0;
            end else begin
                if (push) begin
                    wptr_r <= wptr_r + 1'b1;
                end
                if (pop) begin
                    rptr_r  <= rptr_r + 1'b1;
                    rd_data <= mem[rptr_r];
                end
            end
        end
    end

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/xillybus_rd_stream_arbiter.sv
// Round-robin packet arbiter multiplexing NUM_SRC producers onto one Xillybus
// read channel, prefixing each packet with {magic, id, length}.
module xillybus_rd_stream_arbiter
    import xvs_pkg::*;
#(
    parameter int          NUM_SRC   = 4,
    parameter int          FIFO_AW   = 4,
    parameter logic [7:0]  HDR_MAGIC = 8'hA5
) (
    input  logic                   bus_clk,
    input  logic                   bus_rst,
    input  logic [NUM_SRC-1:0]     src_req,
    input  logic [16*NUM_SRC-1:0]  src_len,
    output logic [NUM_SRC-1:0]     src_grant,
    input  logic [NUM_SRC-1:0]     src_valid,
    input  logic [32*NUM_SRC-1:0]  src_data,
    output logic [NUM_SRC-1:0]     src_ready,
    input  logic                   user_r_rden,
    output logic [31:0]            user_r_data,
    output logic                   user_r_empty,
    output logic                   user_r_eof,
    input  logic                   user_r_open,
    input  logic                   eof_req,
    output logic                   busy
);

    state_t                 state_r;
    state_t                 state_nxt;
    logic [ID_W-1:0]        id_r;
    logic [ID_W-1:0]        id_nxt;
    logic [HDR_LEN_W-1:0]   cnt_r;
    logic [HDR_LEN_W-1:0]   cnt_nxt;
    logic [ID_W-1:0]        rr_ptr_r;
    logic [ID_W-1:0]        rr_nxt;
    logic                   eof_pend_r;
    logic                   open_q_r;

    logic [MAX_SRC-1:0]     req_pad;
    logic [ID_W-1:0]        sel;
    logic [HDR_LEN_W-1:0]   sel_len;
    logic [NUM_SRC-1:0]     id_onehot;
    logic                   cur_valid;
    logic [31:0]            cur_data;

    logic                   fifo_wr;
    logic [31:0]            fifo_din;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign req_pad = MAX_SRC'(src_req);
    assign sel     = rr_first(req_pad, rr_ptr_r, NUM_SRC);

    // Decode the requester being considered and the producer currently owning the channel.
    always_comb begin
        sel_len   = '0;
        id_onehot = '0;
        cur_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            id_onehot[i] = (ID_W'(i) == id_r);
            if (ID_W'(i) == sel) begin
                sel_len = src_len[16*i +: 16];
            end else begin
                sel_len = sel_len;
            end
            if (ID_W'(i) == id_r) begin
                cur_data = src_data[32*i +: 32];
            end else begin
                cur_data = cur_data;
            end
        end
        cur_valid = |(src_valid & id_onehot);
    end

    // Packet FSM: arbitration, header insertion, payload transfer and drain.
    always_comb begin
        state_nxt = state_r;
        id_nxt    = id_r;
        cnt_nxt   = cnt_r;
        rr_nxt    = rr_ptr_r;
        fifo_wr   = 1'b0;
        fifo_din  = '0;
        src_grant = '0;
        src_ready = '0;
        case (state_r)
            IDLE: begin
                if (user_r_open && (|src_req) && !eof_pend_r) begin
                    id_nxt    = sel;
                    cnt_nxt   = sel_len;
                    state_nxt = HDR;
                end else begin
                    state_nxt = IDLE;
                end
            end
            HDR: begin
                // Losing open before the header is out means the producer never learns of it.
                if (!user_r_open) begin
                    state_nxt = IDLE;
                end else if (!fifo_full) begin
                    fifo_wr   = 1'b1;
                    fifo_din  = {HDR_MAGIC, {(HDR_ID_W-ID_W){1'b0}}, id_r, cnt_r};
                    src_grant = id_onehot;
                    if (id_r == ID_W'(NUM_SRC-1)) begin
                        rr_nxt = '0;
                    end else begin
                        rr_nxt = id_r + 1'b1;
                    end
                    state_nxt = (cnt_r == '0) ? IDLE : DATA;
                end else begin
                    state_nxt = HDR;
                end
            end
            DATA: begin
                if (!user_r_open) begin
                    state_nxt = DRAIN;
                end else if (!fifo_full) begin
                    src_ready = id_onehot;
                    if (cur_valid) begin
                        fifo_wr   = 1'b1;
                        fifo_din  = cur_data;
                        cnt_nxt   = cnt_r - 1'b1;
                        state_nxt = (cnt_r == 16'd1) ? IDLE : DATA;
                    end else begin
                        state_nxt = DATA;
                    end
                end else begin
                    state_nxt = DATA;
                end
            end
            DRAIN: begin
                if (cnt_r == '0) begin
                    state_nxt = IDLE;
                end else begin
                    src_ready = id_onehot;
                    if (cur_valid) begin
                        cnt_nxt   = cnt_r - 1'b1;
                        state_nxt = (cnt_r == 16'd1) ? IDLE : DRAIN;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state, packet context, round-robin pointer and sticky EOF request.
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            state_r    <= IDLE;
            id_r       <= '0;
            cnt_r      <= '0;
            rr_ptr_r   <= '0;
            eof_pend_r <= 1'b0;
            open_q_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt;
            id_r     <= id_nxt;
            cnt_r    <= cnt_nxt;
            rr_ptr_r <= rr_nxt;
            open_q_r <= user_r_open;
            if (open_q_r && !user_r_open) begin
                eof_pend_r <= 1'b0;
            end else if (eof_req) begin
                eof_pend_r <= 1'b1;
            end
        end
    end

    xillybus_rd_fifo #(
        .AW (FIFO_AW),
        .DW (32)
    ) u_fifo (
        .clk     (bus_clk),
        .rst     (bus_rst),
        .flush   (~user_r_open),
        .wr_en   (fifo_wr),
        .wr_data (fifo_din),
        .rd_en   (user_r_rden),
        .rd_data (user_r_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign user_r_empty = fifo_empty;
    assign user_r_eof   = eof_pend_r & (state_r == IDLE) & fifo_empty;
    assign busy         = (state_r != IDLE) | ~fifo_empty;

endmodule
